// File: rtl/dicp_table_load.sv
// Loads the DICP compensation table from a byte stream into the compensation RAM.
// Each entry arrives as two bytes, high byte first, and the 16-bit checksum follows the last entry.
module dicp_table_load #(
    parameter int TABLE_DEPTH = 90,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_load_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    output logic        o_dicp_ram_wren,
    output logic [6:0]  o_dicp_ram_wraddr,
    output logic [15:0] o_dicp_ram_wrdata,
    output logic        o_load_busy,
    output logic        o_load_done,
    output logic        o_load_err,
    output logic        o_dicp_valid
);

    localparam int              TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [6:0]      LAST_ADDR = 7'(TABLE_DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_HI,
        GET_LO,
        WRITE,
        CHK_HI,
        CHK_LO,
        DONE,
        ERR
    } state_t;

    state_t           state_q;
    logic [6:0]       cnt_q;
    logic [15:0]      sum_q;
    logic [TMO_W-1:0] tmo_q;
    logic [7:0]       hi_q;
    logic             wren_q;
    logic [6:0]       wraddr_q;
    logic [15:0]      wrdata_q;
    logic             done_q;
    logic             err_q;
    logic             valid_q;

    logic             ready_d;
    logic             accept_d;
    logic             tmo_hit_d;
    logic [15:0]      chk_d;

    assign ready_d   = (state_q == GET_HI) || (state_q == GET_LO) ||
                       (state_q == CHK_HI) || (state_q == CHK_LO);
    assign accept_d  = ready_d && i_byte_valid;
    // A byte accepted in the expiry cycle takes priority over the timeout.
    assign tmo_hit_d = ready_d && !accept_d && (tmo_q == TMO_LAST);
    assign chk_d     = {hi_q, i_byte_data};

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sum_q    <= '0;
            tmo_q    <= '0;
            hi_q     <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;

            if (accept_d) begin
                tmo_q <= '0;
            end else if (ready_d) begin
                tmo_q <= tmo_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (i_load_start) begin
                        state_q <= GET_HI;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        tmo_q   <= '0;
                        valid_q <= 1'b0;
                    end
                end
                GET_HI: begin
                    if (accept_d) begin
                        hi_q    <= i_byte_data;
                        state_q <= GET_LO;
                    end else if (tmo_hit_d) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                GET_LO: begin
                    if (accept_d) begin
                        state_q  <= WRITE;
                        wren_q   <= 1'b1;
                        wraddr_q <= cnt_q;
                        wrdata_q <= chk_d;
                    end else if (tmo_hit_d) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                WRITE: begin
                    // The write strobe was registered on entry, so this cycle only accounts for the entry.
                    sum_q <= sum_q + wrdata_q;
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= CHK_HI;
                    end else begin
                        state_q <= GET_HI;
                    end
                end
                CHK_HI: begin
                    if (accept_d) begin
                        hi_q    <= i_byte_data;
                        state_q <= CHK_LO;
                    end else if (tmo_hit_d) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                CHK_LO: begin
                    if (accept_d) begin
                        if (chk_d == sum_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end else if (tmo_hit_d) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                ERR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_byte_ready      = ready_d;
    assign o_load_busy       = (state_q != IDLE);
    assign o_dicp_ram_wren   = wren_q;
    assign o_dicp_ram_wraddr = wraddr_q;
    assign o_dicp_ram_wrdata = wrdata_q;
    assign o_load_done       = done_q;
    assign o_load_err        = err_q;
    assign o_dicp_valid      = valid_q;

endmodule

// File: tb/tb_dicp_table_load.sv
// Directed bench for dicp_table_load: table of full loads plus timeout, timeout-boundary and mid-load reset sequences.
module tb_dicp_table_load;

    localparam int DEPTH = 90;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        wren;
    logic [6:0]  wraddr;
    logic [15:0] wrdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        dvalid;

    dicp_table_load #(
        .TABLE_DEPTH(DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk_50m        (clk),
        .i_rst_n          (rst_n),
        .i_load_start     (load_start),
        .i_byte_valid     (byte_valid),
        .i_byte_data      (byte_data),
        .o_byte_ready     (byte_ready),
        .o_dicp_ram_wren  (wren),
        .o_dicp_ram_wraddr(wraddr),
        .o_dicp_ram_wrdata(wrdata),
        .o_load_busy      (busy),
        .o_load_done      (done),
        .o_load_err       (err),
        .o_dicp_valid     (dvalid)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Output monitor, sampled on the falling edge.
    int          wren_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          rdy_wr   = 0;
    logic [6:0]  log_addr [0:2047];
    logic [15:0] log_data [0:2047];

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
        if (wren) begin
            log_addr[11'(wren_cnt)] <= wraddr;
            log_data[11'(wren_cnt)] <= wrdata;
            wren_cnt <= wren_cnt + 1;
            if (byte_ready) rdy_wr <= rdy_wr + 1;
        end
    end

    typedef struct {
        int          pat;
        logic [15:0] chk;
        int          start_at;
        logic        exp_done;
        logic        exp_err;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [0:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] entry_val(input int pat, input int a);
        case (pat)
            0:       return 16'(a);
            1:       return 16'hFFFF - 16'(a);
            default: return (a == 0) ? 16'h8123 : (a == 1) ? 16'h7FFF : 16'(a * 257);
        endcase
    endfunction

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("ready_wait_timeout", 32'(g), 0);
        @(negedge clk);
    endtask

    task automatic send_entry(input int pat, input int a);
        logic [15:0] v;
        v = entry_val(pat, a);
        send_byte(v[15:8]);
        send_byte(v[7:0]);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int bw, bd, be, br, nbad;
        logic [10:0] idx;
        logic [15:0] c;
        bw = wren_cnt; bd = done_cnt; be = err_cnt; br = rdy_wr;
        start_load();
        check({tag, "_busy_at_start"}, 32'(busy), 1);
        check({tag, "_valid_cleared"}, 32'(dvalid), 0);
        for (int a = 0; a < DEPTH; a++) begin
            if (a == v.start_at) load_start = 1'b1;
            send_entry(v.pat, a);
            load_start = 1'b0;
        end
        c = v.chk;
        send_byte(c[15:8]);
        send_byte(c[7:0]);
        byte_valid = 1'b0;
        check({tag, "_done_latency"}, 32'(done), 32'(v.exp_done));
        check({tag, "_err_latency"}, 32'(err), 32'(v.exp_err));
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - bd), 32'(v.exp_done));
        check({tag, "_err_pulses"}, 32'(err_cnt - be), 32'(v.exp_err));
        check({tag, "_valid"}, 32'(dvalid), 32'(v.exp_valid));
        check({tag, "_busy_after"}, 32'(busy), 0);
        check({tag, "_wren_pulses"}, 32'(wren_cnt - bw), DEPTH);
        check({tag, "_ready_in_write"}, 32'(rdy_wr - br), 0);
        nbad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = 11'(bw + k);
            if (log_addr[idx] !== 7'(k) || log_data[idx] !== entry_val(v.pat, k)) nbad++;
        end
        check({tag, "_entries"}, 32'(nbad), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bw, be, stall, g;

        // pat, checksum, start-pulse entry, done, err, valid
        vecs[0] = '{0, 16'h0FA5, -1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{0, 16'h0FA6, -1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1, 16'hF001, 30, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{2, 16'hB4C6, -1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{2, 16'h34C6, -1, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(byte_ready), 0);
        check("rst_wren", 32'(wren), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_valid", 32'(dvalid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Source stalls after 10 bytes
        bw = wren_cnt; be = err_cnt;
        start_load();
        for (int a = 0; a < 5; a++) send_entry(0, a);
        byte_valid = 1'b0;
        stall = 0; g = 0;
        while (!err && g < 300) begin
            if (byte_ready) stall++;
            @(negedge clk);
            g++;
        end
        check("tmo_err", 32'(err), 1);
        check("tmo_stall_cycles", 32'(stall), TMO);
        check("tmo_wren_pulses", 32'(wren_cnt - bw), 5);
        check("tmo_valid", 32'(dvalid), 0);
        @(negedge clk);
        check("tmo_busy_after", 32'(busy), 0);
        check("tmo_err_pulses", 32'(err_cnt - be), 1);

        // Byte arriving in the final timeout cycle is accepted
        be = err_cnt;
        start_load();
        send_byte(8'h00);
        byte_valid = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'h00);
        check("tmo_edge_err", 32'(err), 0);
        check("tmo_edge_busy", 32'(busy), 1);
        check("tmo_edge_wren", 32'(wren), 1);

        // Reset in the middle of entry 40
        for (int a = 1; a < 40; a++) send_entry(0, a);
        send_byte(8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(byte_ready), 0);
        check("mid_rst_wren", 32'(wren), 0);
        check("mid_rst_addr", 32'(wraddr), 0);
        check("mid_rst_data", 32'(wrdata), 0);
        check("mid_rst_done_err_valid", 32'({done, err, dvalid}), 0);
        check("mid_rst_no_timeout_err", 32'(err_cnt - be), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        bw = wren_cnt;
        repeat (5) @(negedge clk);
        check("post_rst_idle_ready", 32'(byte_ready), 0);
        check("post_rst_idle_busy", 32'(busy), 0);
        check("post_rst_idle_wren", 32'(wren_cnt - bw), 0);
        byte_valid = 1'b0;
        run_vec(vecs[0], "reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
